// File: rtl/game_timer.sv
// Round countdown timer: loads a mode-selected duration, counts whole seconds from a
// clock prescaler while enabled, and holds Timeout once the count reaches zero.
module game_timer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int SECS_MODE0    = 60,
    parameter int SECS_MODE1    = 30,
    parameter int SECS_MODE2    = 20,
    parameter int SECS_MODE3    = 15,
    parameter int WARN_SECS     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ReconfigTimer,
    input  logic       enable,
    input  logic [1:0] mode,
    output logic       Timeout,
    output logic [6:0] secs_left,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic       tick,
    output logic       warn,
    output logic [1:0] state_dbg
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, EXPIRED} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [6:0]    secs_n, dur_sel;
    logic          to_n, tick_n, warn_n, count_en;

    always_comb begin
        case (mode)
            2'b00:   dur_sel = 7'(SECS_MODE0);
            2'b01:   dur_sel = 7'(SECS_MODE1);
            2'b10:   dur_sel = 7'(SECS_MODE2);
            default: dur_sel = 7'(SECS_MODE3);
        endcase
    end

    assign count_en = enable && !ReconfigTimer && (state == ARMED || state == RUN);

    // Reload wins over counting; a paused RUN keeps its partial second in presc.
    always_comb begin
        state_n = state;
        secs_n  = secs_left;
        presc_n = presc;
        to_n    = Timeout;
        tick_n  = 1'b0;
        if (ReconfigTimer) begin
            state_n = ARMED;
            secs_n  = dur_sel;
            presc_n = '0;
            to_n    = 1'b0;
        end else if (count_en) begin
            state_n = RUN;
            if (presc == PRESC_LAST) begin
                presc_n = '0;
                if (secs_left != 7'd0) begin
                    secs_n = secs_left - 7'd1;
                    tick_n = 1'b1;
                    if (secs_left == 7'd1) begin
                        to_n    = 1'b1;
                        state_n = EXPIRED;
                    end
                end
            end else begin
                presc_n = presc + PW'(1);
            end
        end
        warn_n = (state_n == ARMED || state_n == RUN) &&
                 (secs_n != 7'd0) && (secs_n <= 7'(WARN_SECS));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            presc     <= '0;
            secs_left <= 7'd0;
            Timeout   <= 1'b0;
            tick      <= 1'b0;
            warn      <= 1'b0;
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            secs_left <= secs_n;
            Timeout   <= to_n;
            tick      <= tick_n;
            warn      <= warn_n;
        end
    end

    assign secs_tens = 4'(secs_left / 7'd10);
    assign secs_ones = 4'(secs_left % 7'd10);
    assign state_dbg = state;

endmodule

// File: tb/tb_game_timer.sv
// Randomized and directed checks of game_timer against an elapsed-cycle reference model.
module tb_game_timer;
  localparam int TPS = 4;
  localparam int WARN = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ReconfigTimer = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       Timeout, tick, warn;
  logic [6:0] secs_left;
  logic [3:0] secs_tens, secs_ones;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: duration loaded and number of enabled cycles counted since load
  int durs[4] = '{60, 30, 20, 3};
  bit m_loaded = 0;
  int m_dur = 0;
  int m_e = 0;
  bit m_tick = 0;

  game_timer #(.TICKS_PER_SEC(TPS), .SECS_MODE0(60), .SECS_MODE1(30), .SECS_MODE2(20),
               .SECS_MODE3(3), .WARN_SECS(WARN)) dut (
    .clk(clk), .rst(rst), .ReconfigTimer(ReconfigTimer), .enable(enable), .mode(mode),
    .Timeout(Timeout), .secs_left(secs_left), .secs_tens(secs_tens), .secs_ones(secs_ones),
    .tick(tick), .warn(warn), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic int exp_secs();
    return m_loaded ? (m_dur - m_e / TPS) : 0;
  endfunction

  function automatic bit exp_to();
    return m_loaded && (m_e == TPS * m_dur);
  endfunction

  function automatic bit exp_warn();
    int s = exp_secs();
    return m_loaded && !exp_to() && s >= 1 && s <= WARN;
  endfunction

  // drive one cycle, advance the model on the edge, return 1 time unit after it
  task automatic step(input logic rc, input logic en, input logic [1:0] md);
    ReconfigTimer = rc;
    enable = en;
    mode = md;
    @(posedge clk);
    if (rc) begin
      m_loaded = 1; m_dur = durs[md]; m_e = 0; m_tick = 0;
    end else if (m_loaded && en && m_e < TPS * m_dur) begin
      m_e++;
      m_tick = (m_e % TPS == 0);
    end else begin
      m_tick = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (secs_left !== 7'd0) begin n_fail++; $display("FAIL reset_secs got %0d exp 0", secs_left); end
    n_cmp++; if ({Timeout, tick, warn} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {Timeout, tick, warn}); end
    n_cmp++; if ({secs_tens, secs_ones} !== 8'h00) begin n_fail++; $display("FAIL reset_bcd got %h exp 00", {secs_tens, secs_ones}); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step(0, 1, 2'b11);
    n_cmp++; if (secs_left !== 7'd0 || Timeout !== 1'b0) begin n_fail++; $display("FAIL idle_ignores_enable secs %0d to %b exp 0 0", secs_left, Timeout); end
  endtask

  task automatic test_basic();
    int first_to = -1;
    int ticks = 0;
    step(1, 0, 2'b11);
    n_cmp++; if (secs_left !== 7'd3) begin n_fail++; $display("FAIL basic_load got %0d exp 3", secs_left); end
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, 2'b11);
      if (tick === 1'b1) ticks++;
      if (Timeout === 1'b1 && first_to < 0) first_to = k;
      n_cmp++; if (secs_left !== 7'(exp_secs())) begin n_fail++; $display("FAIL basic_secs cyc %0d got %0d exp %0d", k, secs_left, exp_secs()); end
      n_cmp++; if (tick !== m_tick) begin n_fail++; $display("FAIL basic_tick cyc %0d got %b exp %b", k, tick, m_tick); end
      n_cmp++; if (Timeout !== exp_to()) begin n_fail++; $display("FAIL basic_timeout cyc %0d got %b exp %b", k, Timeout, exp_to()); end
    end
    n_cmp++; if (first_to !== 12) begin n_fail++; $display("FAIL basic_timeout_cycle got %0d exp 12", first_to); end
    n_cmp++; if (ticks !== 3) begin n_fail++; $display("FAIL basic_tick_count got %0d exp 3", ticks); end
  endtask

  task automatic test_pause();
    int en_cnt = 0;
    int first_to = -1;
    step(1, 0, 2'b11);
    repeat (6) begin step(0, 1, 2'b11); en_cnt++; end
    repeat (10) begin
      step(0, 0, 2'b11);
      n_cmp++; if (secs_left !== 7'd2 || tick !== 1'b0) begin n_fail++; $display("FAIL pause_hold got %0d tick %b exp 2 0", secs_left, tick); end
    end
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 2'b11); en_cnt++;
      if (Timeout === 1'b1 && first_to < 0) first_to = en_cnt;
      n_cmp++; if (secs_left !== 7'(exp_secs())) begin n_fail++; $display("FAIL pause_secs got %0d exp %0d", secs_left, exp_secs()); end
    end
    n_cmp++; if (first_to !== 12) begin n_fail++; $display("FAIL pause_timeout_cycle got %0d exp 12", first_to); end
  endtask

  task automatic test_reload_priority();
    step(1, 0, 2'b11);
    repeat (8) step(0, 1, 2'b11);
    n_cmp++; if (secs_left !== 7'd1) begin n_fail++; $display("FAIL prio_setup got %0d exp 1", secs_left); end
    step(1, 1, 2'b01);
    n_cmp++; if (secs_left !== 7'd30) begin n_fail++; $display("FAIL prio_secs got %0d exp 30", secs_left); end
    n_cmp++; if (tick !== 1'b0 || Timeout !== 1'b0) begin n_fail++; $display("FAIL prio_flags got %b%b exp 00", tick, Timeout); end
    repeat (3) step(0, 1, 2'b01);
    n_cmp++; if (secs_left !== 7'd30) begin n_fail++; $display("FAIL prio_presc_restart got %0d exp 30", secs_left); end
    step(0, 1, 2'b01);
    n_cmp++; if (secs_left !== 7'd29 || tick !== 1'b1) begin n_fail++; $display("FAIL prio_first_dec got %0d tick %b exp 29 1", secs_left, tick); end
  endtask

  task automatic test_expired();
    step(1, 0, 2'b11);
    repeat (12) step(0, 1, 2'b11);
    repeat (20) begin
      step(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      n_cmp++; if (Timeout !== 1'b1 || secs_left !== 7'd0 || tick !== 1'b0) begin n_fail++; $display("FAIL expired_hold to %b secs %0d tick %b exp 1 0 0", Timeout, secs_left, tick); end
    end
    step(1, 0, 2'b00);
    n_cmp++; if (Timeout !== 1'b0 || secs_left !== 7'd60) begin n_fail++; $display("FAIL restart to %b secs %0d exp 0 60", Timeout, secs_left); end
    n_cmp++; if (secs_tens !== 4'd6 || secs_ones !== 4'd0) begin n_fail++; $display("FAIL restart_bcd got %0d%0d exp 60", secs_tens, secs_ones); end
  endtask

  task automatic test_warn_bcd();
    step(1, 0, 2'b10);
    for (int k = 0; k < 84; k++) begin
      step(0, 1, 2'b10);
      n_cmp++; if (warn !== exp_warn()) begin n_fail++; $display("FAIL warn secs %0d got %b exp %b", secs_left, warn, exp_warn()); end
      n_cmp++; if (secs_tens !== 4'(exp_secs() / 10) || secs_ones !== 4'(exp_secs() % 10)) begin n_fail++; $display("FAIL bcd got %0d,%0d exp %0d", secs_tens, secs_ones, exp_secs()); end
      if (exp_secs() == 15) begin
        n_cmp++; if (secs_tens !== 4'd1 || secs_ones !== 4'd5) begin n_fail++; $display("FAIL bcd15 got %0d,%0d exp 1,5", secs_tens, secs_ones); end
      end
    end
    n_cmp++; if (warn !== 1'b0 || Timeout !== 1'b1) begin n_fail++; $display("FAIL warn_end warn %b to %b exp 0 1", warn, Timeout); end
  endtask

  task automatic test_reconfig_held();
    logic [1:0] md;
    for (int k = 0; k < 6; k++) begin
      md = 2'($urandom_range(0, 3));
      step(1, 1'($urandom_range(0, 1)), md);
      n_cmp++; if (secs_left !== 7'(durs[md]) || Timeout !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL held secs %0d to %b tick %b exp %0d 0 0", secs_left, Timeout, tick, durs[md]); end
    end
    repeat (TPS) step(0, 1, 2'($urandom_range(0, 3)));
    n_cmp++; if (secs_left !== 7'(durs[md] - 1)) begin n_fail++; $display("FAIL held_release got %0d exp %0d", secs_left, durs[md] - 1); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      step(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)));
      n_cmp++; if (secs_left !== 7'(exp_secs())) begin n_fail++; $display("FAIL rand_secs cyc %0d got %0d exp %0d", k, secs_left, exp_secs()); end
      n_cmp++; if ({Timeout, tick, warn} !== {exp_to(), m_tick, exp_warn()}) begin n_fail++; $display("FAIL rand_flags cyc %0d got %b exp %b", k, {Timeout, tick, warn}, {exp_to(), m_tick, exp_warn()}); end
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 2'b10);
    repeat (70) step(0, 1, 2'b10);
    #3 rst = 1'b0;
    #1;
    m_loaded = 0; m_e = 0; m_tick = 0;
    n_cmp++; if ({Timeout, tick, warn} !== 3'b000 || secs_left !== 7'd0) begin n_fail++; $display("FAIL async_reset flags %b secs %0d exp 000 0", {Timeout, tick, warn}, secs_left); end
    #2 rst = 1'b1;
    repeat (10) step(0, 1, 2'b11);
    n_cmp++; if (secs_left !== 7'd0 || Timeout !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle secs %0d to %b exp 0 0", secs_left, Timeout); end
    step(1, 0, 2'b11);
    n_cmp++; if (secs_left !== 7'd3 || warn !== 1'b1) begin n_fail++; $display("FAIL post_reset_load secs %0d warn %b exp 3 1", secs_left, warn); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_reload_priority();
    test_expired();
    test_warn_bcd();
    test_reconfig_held();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Countdown timer directly downstream of the game controller. It consumes ReconfigTimer (load) and enable (count), and produces Timeout, which feeds back to the controller.
- On load it latches a round duration selected by mode. It counts down whole seconds from a clock prescaler while enabled, and holds Timeout high once expired.
- It also drives seconds-remaining (binary and BCD), a per-second tick pulse and a low-time warning flag for the display.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per second; must be >= 2. The bench uses 4.
- SECS_MODE0, 60, duration in seconds for mode 2'b00; range 1..99.
- SECS_MODE1, 30, duration for mode 2'b01; range 1..99.
- SECS_MODE2, 20, duration for mode 2'b10; range 1..99.
- SECS_MODE3, 15, duration for mode 2'b11; range 1..99.
- WARN_SECS, 5, warn is asserted when secs_left <= WARN_SECS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous active-low reset
- ReconfigTimer  input  1  load request; level-sensitive, reloads on every cycle it is high
- enable  input  1  count enable; high = run, low = pause
- mode  input  2  duration select, sampled only while ReconfigTimer=1
- Timeout  output  1  registered; high while expired
- secs_left  output  7  registered seconds remaining, binary
- secs_tens  output  4  BCD tens digit of secs_left (combinational)
- secs_ones  output  4  BCD ones digit of secs_left (combinational)
- tick  output  1  registered one-cycle pulse on each second decrement
- warn  output  1  registered low-time flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, prescaler=0, secs_left=0, Timeout=0, tick=0, warn=0.
- States: IDLE, ARMED, RUN, EXPIRED.
- Priority each edge: ReconfigTimer first, then counting. There is no other event.
- ReconfigTimer=1, from any state:
  - secs_left <= SECS_MODEn for the current mode; prescaler <= 0; Timeout <= 0; tick <= 0; state <= ARMED.
  - No counting occurs on that edge, even if enable=1.
- count_en = enable && !ReconfigTimer && (state==ARMED || state==RUN).
- ARMED with count_en: state <= RUN and the prescaler increments on the same edge.
- RUN with enable=0: prescaler, secs_left and state hold (pause). Counting resumes with no loss of partial second.
- Prescaler: increments on each count_en edge.
  - When prescaler == TICKS_PER_SEC-1 and count_en: prescaler <= 0, secs_left <= secs_left-1, tick <= 1 for one cycle.
  - Otherwise tick <= 0.
- Expiry: on the decrement that takes secs_left from 1 to 0:
  - Timeout <= 1 on that same edge; state <= EXPIRED.
  - Timeout rises exactly TICKS_PER_SEC*duration enabled cycles after load.
- EXPIRED:
  - Timeout stays 1 and secs_left stays 0; enable is ignored.
  - Only ReconfigTimer leaves EXPIRED (to ARMED, Timeout cleared on that edge).
- IDLE: enable is ignored; secs_left=0 and Timeout=0 until the first load. Timeout never asserts from IDLE.
- No underflow: secs_left never decrements below 0.
- Prescaler width: clog2(TICKS_PER_SEC).
- warn <= 1 when the next-state secs_left is in 1..WARN_SECS and the next state is ARMED or RUN; otherwise 0.
  - warn is 0 in IDLE and EXPIRED.
- BCD: secs_tens = secs_left/10 and secs_ones = secs_left%10, valid for 0..99.
- ReconfigTimer held high for many cycles (RECONFIG phase): reloads every cycle. A mode change while it is held takes effect on the next edge. The last value wins at release.
- Reset mid-count: all outputs return to their reset values immediately, without waiting for a clock edge.

Test Plan:
- Basic countdown:
  - Stimulus: TICKS_PER_SEC=4, SECS_MODE3=3, mode=11, ReconfigTimer pulsed 1 cycle, then enable=1 continuously.
  - Response: secs_left 3->2->1->0, decrementing every 4 cycles; tick pulses 3 times; Timeout rises on enabled cycle 12 and stays high.
- Pause/resume:
  - Stimulus: same setup; drop enable for 10 cycles after 6 enabled cycles.
  - Response: secs_left holds at 2 during the pause; Timeout rises after exactly 12 total enabled cycles.
- Reload priority:
  - Stimulus: ReconfigTimer=1 and enable=1 together during RUN with secs_left=1, mode=01, SECS_MODE1=30.
  - Response: secs_left=30, prescaler restarts, no tick, Timeout stays 0.
- Expired hold and restart:
  - Stimulus: after Timeout=1, toggle enable for 20 cycles, then pulse ReconfigTimer with mode=00.
  - Response: Timeout=1 and secs_left=0 throughout the toggling; after the reload pulse Timeout=0 and secs_left=60 (tens=6, ones=0).
- Warn and BCD:
  - Stimulus: SECS_MODE2=20, WARN_SECS=5, run to completion.
  - Response: warn=0 while secs_left >= 6; warn=1 at 5..1; warn=0 once Timeout=1. secs_left=15 shows tens=1, ones=5.
- Async reset:
  - Stimulus: assert rst=0 mid-RUN between clock edges.
  - Response: Timeout, tick, warn and secs_left go to 0 immediately; enable=1 after release has no effect until a ReconfigTimer pulse.
